seq_write_buffer: RTL and testbench

Write-side buffer between the floating-point arithmetic sequence generator's memory port and a single-port word SRAM. It accepts each single-cycle byte-addressed write, queues it in a small FIFO, and returns a one-cycle `mem_ready` acknowledge. It drains the queue to the SRAM under an arbiter grant, so generator progress is decoupled from SRAM contention.

---
 rtl/seq_mem_pkg.sv | 16 +
 rtl/seq_write_buffer_if.sv | 24 ++
 rtl/seq_wr_fifo.sv | 52 +++++
 rtl/seq_write_buffer.sv | 96 +++++++++
 tb/tb_seq_write_buffer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mem_pkg.sv
// Shared types for the sequence generator's write path: default SRAM geometry,
// the queued entry format and the capture FSM encoding.
package seq_mem_pkg;

    localparam int SRAM_AW_DEFAULT = 10;

    typedef struct packed {
        logic [SRAM_AW_DEFAULT-1:0] addr;
        logic [31:0]                data;
    } seq_wr_entry_t;

    typedef logic cap_state_t;
    localparam cap_state_t CAP_IDLE  = 1'b0;
    localparam cap_state_t CAP_STALL = 1'b1;

endpackage

// File: rtl/seq_write_buffer_if.sv
// Generator write port plus SRAM arbiter port of the write buffer.
// The slave modport is the buffer's view; master is the surrounding system's view.
interface seq_write_buffer_if #(
    parameter int SRAM_AW = seq_mem_pkg::SRAM_AW_DEFAULT
);
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_write;
    logic               mem_ready;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic               sram_gnt;

    modport master (
        output mem_addr, mem_wdata, mem_write, sram_gnt,
        input  mem_ready, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_write, sram_gnt,
        output mem_ready, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/seq_wr_fifo.sv
// Synchronous FIFO with a combinational head read; push is accepted when full
// only if a pop happens in the same cycle.
module seq_wr_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = seq_mem_pkg::seq_wr_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     wr_entry,
    output entry_t                     rd_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full     = (count_q == LW'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rd_entry = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wr_entry;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/seq_write_buffer.sv
// Write-side buffer: acks generator writes, queues valid ones and drains them
// to the SRAM under arbiter grant.
module seq_write_buffer import seq_mem_pkg::*; #(
    parameter int DEPTH   = 4,
    parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    seq_write_buffer_if.slave          bus,
    input  logic                       err_clr,
    output logic                       err,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [31:0]        data;
    } entry_t;

    cap_state_t state_q, state_d;
    logic       ready_q, ready_d;
    logic       err_q, err_d;
    logic       push, pop, space, req_valid;
    logic       fifo_full, fifo_empty;
    entry_t     wr_entry, rd_entry;

    assign req_valid = (bus.mem_addr[1:0] == 2'b00) && (bus.mem_addr[31:SRAM_AW+2] == '0);
    assign pop       = !fifo_empty && bus.sram_gnt;
    assign space     = !fifo_full || pop;
    assign wr_entry  = '{addr: bus.mem_addr[SRAM_AW+1:2], data: bus.mem_wdata};

    // A request seen while the previous ack is still high is a protocol violation and dropped.
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        push    = 1'b0;
        err_d   = err_clr ? 1'b0 : err_q;
        case (state_q)
            CAP_IDLE: begin
                if (bus.mem_write && !ready_q) begin
                    if (!req_valid) begin
                        err_d   = 1'b1;
                        ready_d = 1'b1;
                    end else if (space) begin
                        push    = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        state_d = CAP_STALL;
                    end
                end
            end
            CAP_STALL: begin
                if (space) begin
                    push    = 1'b1;
                    ready_d = 1'b1;
                    state_d = CAP_IDLE;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAP_IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    seq_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign bus.mem_ready  = ready_q;
    assign bus.sram_we    = !fifo_empty;
    assign bus.sram_addr  = rd_entry.addr;
    assign bus.sram_wdata = rd_entry.data;
    assign err            = err_q;
    assign empty          = fifo_empty && (state_q == CAP_IDLE);
endmodule

// File: tb/tb_seq_write_buffer.sv
// Directed bench for seq_write_buffer: vector table of single writes plus
// hand-written stall, protocol, error, random-grant and reset sequences.
module tb_seq_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [31:0]   addr;
        logic [31:0]   data;
        logic          we;
        logic [AW-1:0] saddr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          err_clr;
    logic          err;
    logic          empty;
    logic [LW-1:0] level;

    int            passed = 0;
    int            total  = 0;
    bit            rand_gnt = 1'b0;
    logic [31:0]   sram_mem [1024];
    logic [AW-1:0] log_addr [$];
    logic [31:0]   log_data [$];
    vec_t          vecs [7];
    logic [31:0]   gen_vals [5];

    seq_write_buffer_if #(.SRAM_AW(AW)) bus ();

    seq_write_buffer #(
        .DEPTH   (DEPTH),
        .SRAM_AW (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_clr (err_clr),
        .err     (err),
        .empty   (empty),
        .level   (level)
    );

    always #5 clk = ~clk;

    // SRAM model: records every completed write in order.
    always @(posedge clk) begin
        if (bus.sram_we === 1'b1 && bus.sram_gnt === 1'b1) begin
            sram_mem[bus.sram_addr] <= bus.sram_wdata;
            log_addr.push_back(bus.sram_addr);
            log_data.push_back(bus.sram_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_gnt) bus.sram_gnt = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_full();
        for (int i = 0; i < DEPTH; i++) begin
            bus.mem_addr  = 32'h300 + 32'(4 * i);
            bus.mem_wdata = 32'h4000_0000 + 32'(i);
            bus.mem_write = 1'b1;
            tick();
            bus.mem_write = 1'b0;
            check($sformatf("fill_ready%0d", i), 32'(bus.mem_ready), 32'd1);
            check($sformatf("fill_level%0d", i), 32'(level), 32'(i + 1));
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int k;

        vecs[0] = '{32'h0000_0100, 32'h3F80_0000, 1'b1, 10'h040};
        vecs[1] = '{32'h0000_0102, 32'h1234_5678, 1'b0, 10'h000};
        vecs[2] = '{32'h0000_1000, 32'h4000_0000, 1'b0, 10'h000};
        vecs[3] = '{32'h0000_0FFC, 32'hBF80_0000, 1'b1, 10'h3FF};
        vecs[4] = '{32'h0000_0000, 32'h7F80_0000, 1'b1, 10'h000};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 10'h000};
        vecs[6] = '{32'h0000_0001, 32'hDEAD_BEEF, 1'b0, 10'h000};
        gen_vals = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h4020_0000, 32'h4040_0000};

        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        bus.sram_gnt  = 1'b0;
        err_clr       = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_sram_we", 32'(bus.sram_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        tick();

        // Table of single writes with the grant held high.
        bus.sram_gnt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n0 = log_addr.size();
            bus.mem_addr  = vecs[i].addr;
            bus.mem_wdata = vecs[i].data;
            bus.mem_write = 1'b1;
            tick();
            bus.mem_write = 1'b0;
            check($sformatf("vec%0d_ready", i), 32'(bus.mem_ready), 32'd1);
            check($sformatf("vec%0d_we", i), 32'(bus.sram_we), 32'(vecs[i].we));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(!vecs[i].we));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d_saddr", i), 32'(bus.sram_addr), 32'(vecs[i].saddr));
                check($sformatf("vec%0d_sdata", i), bus.sram_wdata, vecs[i].data);
            end
            tick();
            check($sformatf("vec%0d_ready_low", i), 32'(bus.mem_ready), 32'd0);
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'd1);
            check($sformatf("vec%0d_wcount", i), 32'(log_addr.size() - n0), 32'(vecs[i].we));
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check($sformatf("vec%0d_err_clr", i), 32'(err), 32'd0);
        end

        // mem_write held into the ack cycle must be ignored.
        n0 = log_addr.size();
        bus.mem_addr  = 32'h400;
        bus.mem_wdata = 32'h1111_1111;
        bus.mem_write = 1'b1;
        tick();
        check("viol_ack", 32'(bus.mem_ready), 32'd1);
        bus.mem_addr  = 32'h404;
        bus.mem_wdata = 32'h2222_2222;
        tick();
        bus.mem_write = 1'b0;
        check("viol_no_ack", 32'(bus.mem_ready), 32'd0);
        tick();
        check("viol_wcount", 32'(log_addr.size() - n0), 32'd1);
        check("viol_addr", 32'(log_addr[n0]), 32'h100);

        // Burst with grant low: four acks, fifth stalls until the first pop.
        bus.sram_gnt = 1'b0;
        n0 = log_addr.size();
        fill_full();
        bus.mem_addr  = 32'h310;
        bus.mem_wdata = 32'h4000_0004;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        check("stall_no_ack", 32'(bus.mem_ready), 32'd0);
        check("stall_level", 32'(level), 32'd4);
        check("stall_empty", 32'(empty), 32'd0);
        check("stall_head", 32'(bus.sram_addr), 32'h0C0);
        tick();
        tick();
        check("stall_hold_ready", 32'(bus.mem_ready), 32'd0);
        check("stall_hold_level", 32'(level), 32'd4);
        bus.sram_gnt = 1'b1;
        tick();
        check("stall_ack", 32'(bus.mem_ready), 32'd1);
        check("stall_ack_level", 32'(level), 32'd4);
        check("stall_first_pop", 32'(log_addr.size() - n0), 32'd1);
        tick();
        bus.mem_addr  = 32'h314;
        bus.mem_wdata = 32'h4000_0005;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        check("burst6_ack", 32'(bus.mem_ready), 32'd1);
        k = 0;
        while (!empty && k < 20) begin
            tick();
            k++;
        end
        check("burst_drain", 32'(empty), 32'd1);
        check("burst_wcount", 32'(log_addr.size() - n0), 32'd6);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("burst_addr%0d", j),
                  (log_addr.size() > n0 + j) ? 32'(log_addr[n0 + j]) : 32'hFFFF_FFFF,
                  32'h0C0 + 32'(j));
            check($sformatf("burst_data%0d", j),
                  (log_data.size() > n0 + j) ? log_data[n0 + j] : 32'hFFFF_FFFF,
                  32'h4000_0000 + 32'(j));
        end

        // Sticky error: set by misaligned, set wins over a coincident clear.
        bus.mem_addr  = 32'h102;
        bus.mem_wdata = 32'h0;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        check("mis_ack", 32'(bus.mem_ready), 32'd1);
        check("mis_err", 32'(err), 32'd1);
        check("mis_no_we", 32'(bus.sram_we), 32'd0);
        tick();
        bus.mem_addr  = 32'h1000;
        bus.mem_write = 1'b1;
        err_clr       = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        err_clr       = 1'b0;
        check("err_set_wins", 32'(err), 32'd1);
        check("oor_ack", 32'(bus.mem_ready), 32'd1);
        check("oor_no_we", 32'(bus.sram_we), 32'd0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'd0);

        // Arithmetic sequence 1.0 + 0.5*i at 0x200 under a random grant.
        rand_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.mem_addr  = 32'h200 + 32'(4 * i);
            bus.mem_wdata = gen_vals[i];
            bus.mem_write = 1'b1;
            tick();
            bus.mem_write = 1'b0;
            k = 0;
            while (!bus.mem_ready && k < 50) begin
                tick();
                k++;
            end
            check($sformatf("gen_ack%0d", i), 32'(bus.mem_ready), 32'd1);
            tick();
        end
        k = 0;
        while (!empty && k < 100) begin
            tick();
            k++;
        end
        rand_gnt = 1'b0;
        check("gen_drain", 32'(empty), 32'd1);
        for (int i = 0; i < 5; i++)
            check($sformatf("gen_word%0d", i), sram_mem[10'h080 + 10'(i)], gen_vals[i]);

        // Reset with a full FIFO and a stalled request.
        bus.sram_gnt = 1'b0;
        fill_full();
        bus.mem_addr  = 32'h310;
        bus.mem_wdata = 32'h4000_0004;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        check("pre_rst_level", 32'(level), 32'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_we", 32'(bus.sram_we), 32'd0);
        check("mid_rst_ready", 32'(bus.mem_ready), 32'd0);
        bus.sram_gnt = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n0 = log_addr.size();
        tick();
        tick();
        check("post_rst_no_write", 32'(log_addr.size() - n0), 32'd0);
        check("post_rst_no_ready", 32'(bus.mem_ready), 32'd0);
        bus.mem_addr  = 32'h100;
        bus.mem_wdata = 32'h3F80_0000;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_write = 1'b0;
        check("post_rst_ack", 32'(bus.mem_ready), 32'd1);
        check("post_rst_we", 32'(bus.sram_we), 32'd1);
        check("post_rst_saddr", 32'(bus.sram_addr), 32'h040);
        check("post_rst_sdata", bus.sram_wdata, 32'h3F80_0000);
        tick();
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_wcount", 32'(log_addr.size() - n0), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
